ddp_hdr_arb: RTL and testbench

Round-robin arbiter that shares the single RDMAP-to-DDP header port (`rdmap2DdpHeader`/`rdmap2DdpCtrl`/`rdmap2DdpHdrValid`) of the DDP block between several RDMAP header sources, for example send, write, read-request and read-response engines. It sits directly in front of DDP. It registers the winning header, holds it under downstream backpressure, and grants bounded bursts to the current owner so that multi-segment messages stay contiguous.

---
 rtl/ddp_hdr_arb_if.sv | 30 +++
 rtl/ddp_hdr_arb.sv | 119 +++++++++++
 tb/tb_ddp_hdr_arb.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ddp_hdr_arb_if.sv
// Header-port bundle between RDMAP header sources and the DDP header arbiter.
// slave = arbiter side, master = requester/DDP side.
interface ddp_hdr_arb_if #(
    parameter int NREQ   = 4,
    parameter int HDR_W  = 56,
    parameter int CTRL_W = 8
);
    localparam int GID_W = $clog2(NREQ);

    logic [NREQ-1:0]        reqValid;
    logic [NREQ*HDR_W-1:0]  reqHeader;
    logic [NREQ*CTRL_W-1:0] reqCtrl;
    logic [NREQ-1:0]        reqReady;
    logic                   hdrReady;
    logic                   rdmap2DdpHdrValid;
    logic [HDR_W-1:0]       rdmap2DdpHeader;
    logic [CTRL_W-1:0]      rdmap2DdpCtrl;
    logic [GID_W-1:0]       grantId;
    logic                   busy;

    modport slave (
        input  reqValid, reqHeader, reqCtrl, hdrReady,
        output reqReady, rdmap2DdpHdrValid, rdmap2DdpHeader, rdmap2DdpCtrl, grantId, busy
    );

    modport master (
        output reqValid, reqHeader, reqCtrl, hdrReady,
        input  reqReady, rdmap2DdpHdrValid, rdmap2DdpHeader, rdmap2DdpCtrl, grantId, busy
    );
endinterface

// File: rtl/ddp_hdr_arb.sv
// Round-robin burst arbiter feeding the single RDMAP-to-DDP header port.
// Optional DDP_HDR_ARB_PRIO0_EN: requester 0 preempts without disturbing burst state.
module ddp_hdr_arb #(
    parameter int NREQ      = 4,
    parameter int HDR_W     = 56,
    parameter int CTRL_W    = 8,
    parameter int BURST_MAX = 4
) (
    input logic           clock,
    input logic           reset,
    ddp_hdr_arb_if.slave  bus
);
    localparam int GID_W = $clog2(NREQ);

    typedef enum logic {IDLE, BURST} state_e;

    state_e              state_q;
    logic [GID_W-1:0]    ptr_q, owner_q, gid_q;
    logic [3:0]          cnt_q;
    logic                vld_q;
    logic [HDR_W-1:0]    hdr_q;
    logic [CTRL_W-1:0]   ctrl_q;

    logic                load, anyReq, grant, keep, prioHit;
    logic [NREQ-1:0]     rrMask;
    logic [GID_W-1:0]    rrStart, rrWin, win;
    logic [HDR_W-1:0]    winHdr;
    logic [CTRL_W-1:0]   winCtrl;

    // Explicit wrap so non-power-of-two NREQ stays in range.
    function automatic logic [GID_W-1:0] inc(input logic [GID_W-1:0] x);
        return (x == GID_W'(NREQ - 1)) ? '0 : x + 1'b1;
    endfunction

    function automatic logic [GID_W-1:0] scan(input logic [NREQ-1:0] v,
                                              input logic [GID_W-1:0] start);
        logic [GID_W-1:0] res;
        logic             found;
        logic [GID_W-1:0] jj;
        int               j;
        res   = start;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(start) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = GID_W'(j);
            if (!found && v[jj]) begin
                found = 1'b1;
                res   = jj;
            end
        end
        return res;
    endfunction

    always_comb begin
        load    = !vld_q || bus.hdrReady;
        anyReq  = |bus.reqValid;
        grant   = load && anyReq;
        rrMask  = bus.reqValid;
`ifdef DDP_HDR_ARB_PRIO0_EN
        rrMask[0] = 1'b0;
        prioHit   = bus.reqValid[0];
`else
        prioHit   = 1'b0;
`endif
        keep    = (state_q == BURST) && bus.reqValid[owner_q] && (cnt_q < 4'(BURST_MAX));
        // Starting after the owner leaves the owner as the last candidate.
        rrStart = (state_q == BURST) ? inc(owner_q) : ptr_q;
        rrWin   = scan(rrMask, rrStart);
        win     = prioHit ? '0 : (keep ? owner_q : rrWin);
    end

    always_comb begin
        winHdr  = '0;
        winCtrl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == GID_W'(i)) begin
                winHdr  = bus.reqHeader[i*HDR_W +: HDR_W];
                winCtrl = bus.reqCtrl[i*CTRL_W +: CTRL_W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            hdr_q   <= '0;
            ctrl_q  <= '0;
            gid_q   <= '0;
        end else if (load) begin
            vld_q <= anyReq;
            if (anyReq) begin
                hdr_q  <= winHdr;
                ctrl_q <= winCtrl;
                gid_q  <= win;
                // Priority grants leave the round-robin/burst state untouched.
                if (!prioHit) begin
                    state_q <= BURST;
                    owner_q <= win;
                    cnt_q   <= keep ? cnt_q + 4'd1 : 4'd1;
                end
            end else if (state_q == BURST) begin
                state_q <= IDLE;
                ptr_q   <= inc(owner_q);
            end
        end
    end

    assign bus.reqReady          = grant ? (NREQ'(1) << win) : '0;
    assign bus.rdmap2DdpHdrValid = vld_q;
    assign bus.rdmap2DdpHeader   = hdr_q;
    assign bus.rdmap2DdpCtrl     = ctrl_q;
    assign bus.grantId           = gid_q;
    assign bus.busy              = vld_q || (state_q == BURST);
endmodule

// File: tb/tb_ddp_hdr_arb.sv
// Directed bench for ddp_hdr_arb: vector table plus hand-written corner sequences.
module tb_ddp_hdr_arb;
    localparam int NREQ = 4, HDR_W = 56, CTRL_W = 8, BURST_MAX = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ddp_hdr_arb_if #(.NREQ(NREQ), .HDR_W(HDR_W), .CTRL_W(CTRL_W)) bus();

    ddp_hdr_arb #(.NREQ(NREQ), .HDR_W(HDR_W), .CTRL_W(CTRL_W), .BURST_MAX(BURST_MAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       rdy;
        logic [3:0] er;
        logic       ev;
        logic [1:0] eg;
        logic       eb;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [HDR_W-1:0] hdrOf(input int i);
        return {8'(i + 1), 48'h0000_C0FF_EE00 + 48'(i) * 48'h1357};
    endfunction

    function automatic logic [CTRL_W-1:0] ctrlOf(input int i);
        return 8'(8'h5A ^ (i * 17));
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic rdy,
                                input logic [3:0] er, input logic ev, input logic [1:0] eg,
                                input logic eb);
        vec_t t;
        t.rst = r; t.v = v; t.rdy = rdy; t.er = er; t.ev = ev; t.eg = eg; t.eb = eb;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_dut();
        @(negedge clock);
        reset = 1'b1;
        bus.reqValid = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic step(input logic [3:0] v, input logic rdy, input logic [3:0] er,
                        input logic ev, input logic [1:0] eg, input logic eb);
        @(negedge clock);
        bus.reqValid = v;
        bus.hdrReady = rdy;
        #1;
        chk("reqReady", 64'(bus.reqReady), 64'(er));
        @(posedge clock);
        #1;
        chk("hdrValid", 64'(bus.rdmap2DdpHdrValid), 64'(ev));
        chk("busy", 64'(bus.busy), 64'(eb));
        if (ev) begin
            chk("grantId", 64'(bus.grantId), 64'(eg));
            chk("header", 64'(bus.rdmap2DdpHeader), 64'(hdrOf(int'(eg))));
            chk("ctrl", 64'(bus.rdmap2DdpCtrl), 64'(ctrlOf(int'(eg))));
        end
    endtask

    initial begin
        logic [1:0] seq2 [13];
        seq2 = '{0,0,0,0,1,1,1,1,2,2,2,2,3};

        bus.reqValid = '0;
        bus.hdrReady = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            bus.reqHeader[i*HDR_W +: HDR_W]   = hdrOf(i);
            bus.reqCtrl[i*CTRL_W +: CTRL_W]   = ctrlOf(i);
        end

        // Single requester streams back-to-back, then goes quiet.
        for (int i = 0; i < 6; i++) tbl.push_back(mk(i == 0, 4'b0001, 1, 4'b0001, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 0));
`ifndef DDP_HDR_ARB_PRIO0_EN
        // All requesting: bursts of BURST_MAX rotate with no gaps.
        for (int i = 0; i < 13; i++)
            tbl.push_back(mk(i == 0, 4'b1111, 1, 4'(1 << seq2[i]), 1, seq2[i], 1));
`endif
        // Requester 1 burst interrupted: ptr moves to 2, so 0011 picks 0.
        tbl.push_back(mk(1, 4'b0010, 1, 4'b0010, 1, 1, 1));
        tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 1, 1, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0001, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0001, 1, 0, 1));

        repeat (2) @(negedge clock);
        chk("rst_valid", 64'(bus.rdmap2DdpHdrValid), 64'd0);
        chk("rst_header", 64'(bus.rdmap2DdpHeader), 64'd0);
        chk("rst_ctrl", 64'(bus.rdmap2DdpCtrl), 64'd0);
        chk("rst_gid", 64'(bus.grantId), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ready", 64'(bus.reqReady), 64'd0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            if (tbl[i].rst) reset_dut();
            step(tbl[i].v, tbl[i].rdy, tbl[i].er, tbl[i].ev, tbl[i].eg, tbl[i].eb);
        end

`ifndef DDP_HDR_ARB_PRIO0_EN
        // Backpressure on a header from requester 2, then same-cycle reload.
        reset_dut();
        step(4'b0100, 1, 4'b0100, 1, 2, 1);
        for (int i = 0; i < 5; i++) step(4'b1011, 0, 4'b0000, 1, 2, 1);
        step(4'b1011, 1, 4'b1000, 1, 3, 1);
`endif

        // Asynchronous reset mid-cycle while a header is stalled.
        reset_dut();
        step(4'b0100, 1, 4'b0100, 1, 2, 1);
        @(negedge clock);
        bus.reqValid = 4'b0000;
        bus.hdrReady = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.rdmap2DdpHdrValid), 64'd0);
        chk("arst_header", 64'(bus.rdmap2DdpHeader), 64'd0);
        chk("arst_ctrl", 64'(bus.rdmap2DdpCtrl), 64'd0);
        chk("arst_gid", 64'(bus.grantId), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_ready", 64'(bus.reqReady), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        step(4'b1111, 1, 4'b0001, 1, 0, 1);

`ifdef DDP_HDR_ARB_PRIO0_EN
        // Requester 0 preempts requester 3's burst, which then resumes at count 3.
        reset_dut();
        step(4'b1000, 1, 4'b1000, 1, 3, 1);
        step(4'b1000, 1, 4'b1000, 1, 3, 1);
        step(4'b1001, 1, 4'b0001, 1, 0, 1);
        step(4'b1010, 1, 4'b1000, 1, 3, 1);
        step(4'b1010, 1, 4'b1000, 1, 3, 1);
        step(4'b1010, 1, 4'b0010, 1, 1, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
